// File: rtl/accel_trace_dispatcher.sv
// Host-loaded accelerator request dispatcher: replays a loaded request list to Ara,
// bounds in-flight responses with credit, and reports completion with counters.
module accel_trace_dispatcher #(
   parameter int unsigned XLEN           = 64,
   parameter int unsigned Depth          = 64,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned LoopCntWidth   = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    load_valid_i,
   output logic                    load_ready_o,
   input  logic [31:0]             load_insn_i,
   input  logic [XLEN-1:0]         load_rs1_i,
   input  logic [XLEN-1:0]         load_rs2_i,
   input  logic                    load_resp_i,
   input  logic                    start_i,
   input  logic [LoopCntWidth-1:0] loop_cnt_i,
   input  logic                    clear_i,
   output logic                    acc_req_valid_o,
   input  logic                    acc_req_ready_i,
   output logic [31:0]             acc_insn_o,
   output logic [XLEN-1:0]         acc_rs1_o,
   output logic [XLEN-1:0]         acc_rs2_o,
   input  logic                    acc_resp_valid_i,
   output logic                    acc_resp_ready_o,
   input  logic [XLEN-1:0]         acc_resp_result_i,
   input  logic                    ara_idle_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    error_o,
   output logic [63:0]             cycle_cnt_o,
   output logic [31:0]             dispatch_cnt_o,
   output logic [XLEN-1:0]         last_result_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned OW = $clog2(MaxOutstanding + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   typedef struct packed {
      logic [31:0]     insn;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic            resp;
   } entry_t;

   entry_t                  mem_q [Depth];
   entry_t                  head;
   state_e                  state_q, state_d;
   logic [CW-1:0]           wr_ptr_q, count_q, rd_ptr_q;
   logic [LoopCntWidth-1:0] pass_q;
   logic [OW-1:0]           outst_q;
   logic [63:0]             cycle_cnt_q;
   logic [31:0]             dispatch_cnt_q;
   logic                    error_q;
   logic [XLEN-1:0]         last_result_q;

   logic load_fire, req_fire, start_fire, clear_fire;
   logic last_in_pass, credit_full, resp_inc;
   logic unused_wr_msb;

   // Only the low bits address the array; the MSB just mirrors count.
   assign unused_wr_msb = wr_ptr_q[CW-1];

   assign head         = mem_q[rd_ptr_q[AW-1:0]];
   assign credit_full  = (outst_q == OW'(MaxOutstanding));
   assign last_in_pass = (rd_ptr_q == count_q - CW'(1));

   assign load_ready_o     = (state_q == IDLE) && (count_q < CW'(Depth));
   assign acc_req_valid_o  = (state_q == RUN) && !(head.resp && credit_full);
   assign acc_insn_o       = head.insn;
   assign acc_rs1_o        = head.rs1;
   assign acc_rs2_o        = head.rs2;
   assign acc_resp_ready_o = 1'b1;
   assign busy_o           = (state_q == RUN) || (state_q == DRAIN);
   assign done_o           = (state_q == DONE);
   assign error_o          = error_q;
   assign cycle_cnt_o      = cycle_cnt_q;
   assign dispatch_cnt_o   = dispatch_cnt_q;
   assign last_result_o    = last_result_q;

   assign load_fire  = load_valid_i && load_ready_o;
   assign req_fire   = acc_req_valid_o && acc_req_ready_i;
   assign start_fire = (state_q == IDLE) && start_i;
   assign clear_fire = (state_q == DONE) && clear_i;
   assign resp_inc   = req_fire && head.resp;

   // NOTE: the request array carries no reset; count_q alone defines which entries are valid.
   always_ff @(posedge clk_i) begin
      if (load_fire) begin
         mem_q[wr_ptr_q[AW-1:0]] <= '{insn: load_insn_i, rs1: load_rs1_i,
                                      rs2: load_rs2_i, resp: load_resp_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // NOTE: state_d takes its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_i) state_d = (count_q == '0) ? DRAIN : RUN;
         RUN:   if (req_fire && last_in_pass && pass_q <= LoopCntWidth'(1)) state_d = DRAIN;
         DRAIN: if (outst_q == '0 && ara_idle_i) state_d = DONE;
         DONE:  if (clear_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q       <= '0;
         count_q        <= '0;
         rd_ptr_q       <= '0;
         pass_q         <= '0;
         cycle_cnt_q    <= '0;
         dispatch_cnt_q <= '0;
         error_q        <= 1'b0;
         last_result_q  <= '0;
      end else begin
         if (load_fire) begin
            wr_ptr_q <= wr_ptr_q + CW'(1);
            count_q  <= count_q + CW'(1);
         end
         if (clear_fire) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
         end
         if (start_fire) begin
            rd_ptr_q       <= '0;
            pass_q         <= (loop_cnt_i == '0) ? LoopCntWidth'(1) : loop_cnt_i;
            cycle_cnt_q    <= '0;
            dispatch_cnt_q <= '0;
         end else if (busy_o) begin
            cycle_cnt_q <= cycle_cnt_q + 64'd1;
         end
         if (req_fire) begin
            dispatch_cnt_q <= dispatch_cnt_q + 32'd1;
            if (!last_in_pass) begin
               rd_ptr_q <= rd_ptr_q + CW'(1);
            end else if (pass_q > LoopCntWidth'(1)) begin
               rd_ptr_q <= '0;
               pass_q   <= pass_q - LoopCntWidth'(1);
            end
         end
         if (acc_resp_valid_i) last_result_q <= acc_resp_result_i;
         // A response with no credit outstanding is a protocol error, not an underflow.
         if (start_fire)                             error_q <= 1'b0;
         else if (acc_resp_valid_i && outst_q == '0) error_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outst_q <= '0;
      end else if (start_fire) begin
         outst_q <= '0;
      end else if (resp_inc && !acc_resp_valid_i) begin
         outst_q <= outst_q + OW'(1);
      end else if (!resp_inc && acc_resp_valid_i && outst_q != '0) begin
         outst_q <= outst_q - OW'(1);
      end
   end

endmodule

// File: tb/tb_accel_trace_dispatcher.sv
// Self-checking bench for accel_trace_dispatcher: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_accel_trace_dispatcher;

   localparam int DEPTH = 8;
   localparam int MAXO  = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        load_valid_i = 1'b0;
   logic        load_ready_o;
   logic [31:0] load_insn_i = '0;
   logic [63:0] load_rs1_i = '0, load_rs2_i = '0;
   logic        load_resp_i = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] loop_cnt_i = '0;
   logic        clear_i = 1'b0;
   logic        acc_req_valid_o;
   logic        acc_req_ready_i = 1'b1;
   logic [31:0] acc_insn_o;
   logic [63:0] acc_rs1_o, acc_rs2_o;
   logic        acc_resp_valid_i = 1'b0;
   logic        acc_resp_ready_o;
   logic [63:0] acc_resp_result_i = '0;
   logic        ara_idle_i = 1'b1;
   logic        busy_o, done_o, error_o;
   logic [63:0] cycle_cnt_o;
   logic [31:0] dispatch_cnt_o;
   logic [63:0] last_result_o;

   accel_trace_dispatcher #(
      .XLEN(64), .Depth(DEPTH), .MaxOutstanding(MAXO), .LoopCntWidth(16)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
      .load_insn_i(load_insn_i), .load_rs1_i(load_rs1_i), .load_rs2_i(load_rs2_i),
      .load_resp_i(load_resp_i), .start_i(start_i), .loop_cnt_i(loop_cnt_i),
      .clear_i(clear_i), .acc_req_valid_o(acc_req_valid_o),
      .acc_req_ready_i(acc_req_ready_i), .acc_insn_o(acc_insn_o),
      .acc_rs1_o(acc_rs1_o), .acc_rs2_o(acc_rs2_o),
      .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_ready_o(acc_resp_ready_o),
      .acc_resp_result_i(acc_resp_result_i), .ara_idle_i(ara_idle_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .cycle_cnt_o(cycle_cnt_o), .dispatch_cnt_o(dispatch_cnt_o),
      .last_result_o(last_result_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_e;
   typedef struct packed {
      logic [31:0] insn;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic        resp;
   } ent_t;

   ent_t        mq[$];
   mphase_e     ph = M_IDLE;
   int          m_idx = 0, m_total = 0, m_outst = 0;
   logic [31:0] m_disp = '0;
   logic [63:0] m_cyc = '0, m_last = '0;
   logic        m_err = 1'b0;

   int          cyc_n = 0;
   logic [31:0] hs_insn[$];
   int          hs_edge[$];

   always @(posedge clk_i) cyc_n++;

   always @(negedge clk_i) begin
      ent_t ent;
      logic ev, hs, inc;
      int   old_outst;
      if (!rst_ni) begin
         mq.delete();
         ph = M_IDLE; m_idx = 0; m_total = 0; m_outst = 0;
         m_disp = '0; m_cyc = '0; m_last = '0; m_err = 1'b0;
      end else begin
         ent = '0;
         if (ph == M_RUN) ent = mq[m_idx % mq.size()];
         ev = (ph == M_RUN) && !(ent.resp && m_outst == MAXO);

         check("req_valid", acc_req_valid_o, ev);
         if (ev && acc_req_valid_o) begin
            check("req_insn", acc_insn_o, ent.insn);
            check("req_rs1", acc_rs1_o, ent.rs1);
            check("req_rs2", acc_rs2_o, ent.rs2);
         end
         check("busy", busy_o, (ph == M_RUN || ph == M_DRAIN));
         check("done", done_o, (ph == M_DONE));
         check("error", error_o, m_err);
         check("dispatch_cnt", dispatch_cnt_o, m_disp);
         check("cycle_cnt", cycle_cnt_o, m_cyc);
         check("last_result", last_result_o, m_last);
         check("load_ready", load_ready_o, (ph == M_IDLE && mq.size() < DEPTH));
         check("resp_ready", acc_resp_ready_o, 1'b1);

         if (acc_req_valid_o && acc_req_ready_i) begin
            hs_insn.push_back(acc_insn_o);
            hs_edge.push_back(cyc_n + 1);
         end

         // Effect of the coming clock edge.
         hs  = ev && acc_req_ready_i;
         inc = hs && ent.resp;
         old_outst = m_outst;
         if (acc_resp_valid_i) begin
            m_last = acc_resp_result_i;
            if (m_outst == 0) m_err = 1'b1;
         end
         if (inc && !acc_resp_valid_i) m_outst++;
         else if (!inc && acc_resp_valid_i && m_outst > 0) m_outst--;
         if (ph == M_RUN || ph == M_DRAIN) m_cyc++;
         case (ph)
            M_IDLE: begin
               if (start_i) begin
                  m_disp = '0; m_cyc = '0; m_outst = 0; m_err = 1'b0; m_idx = 0;
                  m_total = mq.size() * ((loop_cnt_i == 0) ? 1 : int'(loop_cnt_i));
                  ph = (mq.size() == 0) ? M_DRAIN : M_RUN;
               end
               if (load_valid_i && mq.size() < DEPTH)
                  mq.push_back('{insn: load_insn_i, rs1: load_rs1_i, rs2: load_rs2_i,
                                 resp: load_resp_i});
            end
            M_RUN: if (hs) begin
               m_disp++;
               m_idx++;
               if (m_idx == m_total) ph = M_DRAIN;
            end
            M_DRAIN: if (old_outst == 0 && ara_idle_i) ph = M_DONE;
            M_DONE: if (clear_i) begin
               mq.delete();
               ph = M_IDLE;
            end
            default: ;
         endcase
      end
   end

   // ---------------- directed stimulus ----------------
   int start_edge = 0;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load(input logic [31:0] insn, input logic resp);
      load_valid_i = 1'b1;
      load_insn_i  = insn;
      load_rs1_i   = {32'h1111_0000, insn};
      load_rs2_i   = {insn, 32'h2222_0000};
      load_resp_i  = resp;
      tick();
      load_valid_i = 1'b0;
   endtask

   task automatic start_run(input logic [15:0] loops);
      loop_cnt_i = loops;
      start_i    = 1'b1;
      tick();
      start_i    = 1'b0;
      start_edge = cyc_n;
   endtask

   task automatic wait_done(input int budget, output int done_edge);
      int n = 0;
      while (!done_o && n < budget) begin
         tick();
         n++;
      end
      check("done_within_budget", done_o, 1'b1);
      done_edge = cyc_n;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   task automatic run_basic(input string tag);
      logic [31:0] exp_insn [3];
      int de;
      exp_insn = '{32'h0000_0A57, 32'h0000_0B57, 32'h0000_0C57};
      hs_insn.delete(); hs_edge.delete();
      for (int i = 0; i < 3; i++) load(exp_insn[i], 1'b0);
      start_run(16'd0);
      wait_done(20, de);
      check({tag, "_done_cycle"}, de - start_edge, 4);
      check({tag, "_num_req"}, hs_insn.size(), 3);
      for (int i = 0; i < 3 && i < hs_insn.size(); i++) begin
         check({tag, "_req_insn"}, hs_insn[i], exp_insn[i]);
         check({tag, "_req_cycle"}, hs_edge[i] - start_edge, i + 1);
      end
      check({tag, "_dispatch_cnt"}, dispatch_cnt_o, 3);
      check({tag, "_cycle_cnt"}, cycle_cnt_o, 4);
   endtask

   initial begin
      int de, r_edge;

      repeat (3) tick();
      check("reset_valid", acc_req_valid_o, 1'b0);
      check("reset_load_ready", load_ready_o, 1'b1);
      check("reset_last_result", last_result_o, 0);
      rst_ni = 1'b1;
      tick();

      // Three plain requests, single pass.
      run_basic("basic");

      // Fill the queue; an extra load must be refused.
      do_clear();
      hs_insn.delete(); hs_edge.delete();
      for (int i = 0; i < DEPTH; i++) load(32'h0000_1000 + i, 1'b0);
      check("full_ready_low", load_ready_o, 1'b0);
      load(32'h0000_BEEF, 1'b0);
      check("full_ready_still_low", load_ready_o, 1'b0);
      start_run(16'd1);
      wait_done(40, de);
      check("full_dispatch_cnt", dispatch_cnt_o, DEPTH);
      if (hs_insn.size() == DEPTH)
         check("full_last_insn", hs_insn[DEPTH-1], 32'h0000_1000 + DEPTH - 1);
      else
         check("full_num_req", hs_insn.size(), DEPTH);

      // Two entries replayed three times.
      do_clear();
      hs_insn.delete(); hs_edge.delete();
      load(32'h0000_0100, 1'b0);
      load(32'h0000_0200, 1'b0);
      start_run(16'd3);
      wait_done(30, de);
      check("loop_dispatch_cnt", dispatch_cnt_o, 6);
      check("loop_num_req", hs_insn.size(), 6);
      for (int i = 0; i < 6 && i < hs_insn.size(); i++)
         check("loop_order", hs_insn[i], (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);

      // Credit limit: four response entries, two credits.
      do_clear();
      hs_insn.delete(); hs_edge.delete();
      for (int i = 0; i < 4; i++) load(32'h0000_0301 + i, 1'b1);
      start_run(16'd1);
      repeat (4) tick();
      check("credit_dispatch_stalled", dispatch_cnt_o, 2);
      check("credit_valid_low", acc_req_valid_o, 1'b0);
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'hA1;
      tick();
      r_edge = cyc_n;
      acc_resp_valid_i = 1'b0;
      tick();
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'hA2;
      tick();
      acc_resp_valid_i = 1'b0;
      tick();
      ara_idle_i = 1'b0;
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'hA3;
      tick();
      tick();
      acc_resp_valid_i = 1'b0;
      repeat (3) tick();
      check("drain_waits_idle", done_o, 1'b0);
      check("drain_busy", busy_o, 1'b1);
      ara_idle_i = 1'b1;
      wait_done(10, de);
      check("credit_third_edge", (hs_edge.size() > 2) ? hs_edge[2] - r_edge : -1, 1);
      check("credit_dispatch_cnt", dispatch_cnt_o, 4);
      check("credit_no_error", error_o, 1'b0);
      check("credit_last_result", last_result_o, 64'hA3);

      // Unsolicited response in IDLE; a later start clears the error.
      do_clear();
      acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'hDEAD_BEEF;
      tick();
      acc_resp_valid_i = 1'b0;
      check("idle_resp_error", error_o, 1'b1);
      check("idle_resp_result", last_result_o, 64'hDEAD_BEEF);
      load(32'h0000_0400, 1'b0);
      start_run(16'd0);
      check("start_clears_error", error_o, 1'b0);
      wait_done(10, de);

      // Empty queue: one DRAIN cycle, then DONE.
      do_clear();
      start_run(16'd0);
      check("empty_busy", busy_o, 1'b1);
      check("empty_not_done", done_o, 1'b0);
      tick();
      check("empty_done", done_o, 1'b1);
      check("empty_cycle_cnt", cycle_cnt_o, 1);
      check("empty_dispatch_cnt", dispatch_cnt_o, 0);

      // Reset in the middle of a run.
      do_clear();
      for (int i = 0; i < 3; i++) load(32'h0000_0500 + i, 1'b0);
      start_run(16'd0);
      rst_ni = 1'b0;
      #1;
      check("rst_valid_low", acc_req_valid_o, 1'b0);
      check("rst_busy_low", busy_o, 1'b0);
      check("rst_counters", dispatch_cnt_o, 0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();

      // Queue must be empty after reset, and a clear/reload reruns identically.
      run_basic("after_reset");
      do_clear();
      run_basic("rerun");

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
